// File: rtl/prog_loader.sv
// Serial program loader: parses a framed byte stream into 18-bit words, writes them
// from address 0 and owns the program memory port while holding the MCU in reset.
module prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 18,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LOAD_REQ,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W:0]   WORD_COUNT
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SYNC, ST_LEN_HI, ST_LEN_LO, ST_B2, ST_B1, ST_B0,
        ST_WRITE, ST_CHECK, ST_FINISH, ST_FAIL
    } state_t;

    state_t            state_r, state_nx_s;
    logic              rx_ready_r, mem_we_r, hold_r, busy_r, done_r, err_r;
    logic [ADDR_W:0]   ptr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [1:0]        len_hi_r, b2_r;
    logic [7:0]        len_lo_r, b1_r, chk_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              accept_s, to_hit_s;
    logic [ADDR_W:0]   n_words_s;

    // Header and B2 bytes only carry two payload bits; anything above them is a framing error.
    function automatic logic fits_2bit(input logic [7:0] b);
        return (b & 8'hFC) == 8'h00;
    endfunction

    function automatic logic ready_state(input state_t s);
        return (s == ST_SYNC) || (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_B2) ||
               (s == ST_B1) || (s == ST_B0) || (s == ST_CHECK);
    endfunction

    // The watchdog is only live once the sync byte has been seen.
    function automatic logic armed_state(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_B2) ||
               (s == ST_B1) || (s == ST_B0) || (s == ST_CHECK);
    endfunction

    assign accept_s  = RX_VALID & rx_ready_r;
    assign to_hit_s  = (to_cnt_r == TO_W'(TIMEOUT_CYC));
    assign n_words_s = (ADDR_W+1)'({len_hi_r, len_lo_r}) + (ADDR_W+1)'(1);

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (LOAD_REQ) state_nx_s = ST_SYNC;
                else          state_nx_s = ST_IDLE;
            end
            ST_SYNC: begin
                if (accept_s && (RX_DATA == 8'hA5)) state_nx_s = ST_LEN_HI;
                else                                state_nx_s = ST_SYNC;
            end
            ST_LEN_HI, ST_B2: begin
                if (accept_s) begin
                    if (!fits_2bit(RX_DATA))        state_nx_s = ST_FAIL;
                    else if (state_r == ST_LEN_HI)  state_nx_s = ST_LEN_LO;
                    else                            state_nx_s = ST_B1;
                end else if (to_hit_s) begin
                    state_nx_s = ST_FAIL;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_LEN_LO, ST_B1, ST_B0: begin
                if (accept_s) begin
                    if (state_r == ST_LEN_LO)   state_nx_s = ST_B2;
                    else if (state_r == ST_B1)  state_nx_s = ST_B0;
                    else                        state_nx_s = ST_WRITE;
                end else if (to_hit_s) begin
                    state_nx_s = ST_FAIL;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WRITE: begin
                if ((ptr_r + (ADDR_W+1)'(1)) == n_words_s) state_nx_s = ST_CHECK;
                else                                       state_nx_s = ST_B2;
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (RX_DATA == chk_r) state_nx_s = ST_FINISH;
                    else                  state_nx_s = ST_FAIL;
                end else if (to_hit_s) begin
                    state_nx_s = ST_FAIL;
                end else begin
                    state_nx_s = ST_CHECK;
                end
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            ST_FAIL:   state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            hold_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            ptr_r      <= '0;
            wdata_r    <= '0;
            len_hi_r   <= 2'd0;
            len_lo_r   <= 8'd0;
            b2_r       <= 2'd0;
            b1_r       <= 8'd0;
            chk_r      <= 8'd0;
            to_cnt_r   <= '0;
        end else begin
            state_r    <= state_nx_s;
            rx_ready_r <= ready_state(state_nx_s);
            mem_we_r   <= (state_nx_s == ST_WRITE);

            if (accept_s || !armed_state(state_r)) to_cnt_r <= '0;
            else if (!to_hit_s)                    to_cnt_r <= to_cnt_r + TO_W'(1);

            case (state_r)
                ST_IDLE: begin
                    if (state_nx_s == ST_SYNC) begin
                        hold_r <= 1'b1;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                        err_r  <= 1'b0;
                        ptr_r  <= '0;
                        chk_r  <= 8'd0;
                    end
                end
                ST_LEN_HI: if (accept_s) begin
                    len_hi_r <= RX_DATA[1:0];
                    chk_r    <= chk_r ^ RX_DATA;
                end
                ST_LEN_LO: if (accept_s) begin
                    len_lo_r <= RX_DATA;
                    chk_r    <= chk_r ^ RX_DATA;
                end
                ST_B2: if (accept_s) begin
                    b2_r  <= RX_DATA[1:0];
                    chk_r <= chk_r ^ RX_DATA;
                end
                ST_B1: if (accept_s) begin
                    b1_r  <= RX_DATA;
                    chk_r <= chk_r ^ RX_DATA;
                end
                ST_B0: if (accept_s) begin
                    wdata_r <= {b2_r, b1_r, RX_DATA};
                    chk_r   <= chk_r ^ RX_DATA;
                end
                ST_WRITE:  ptr_r <= ptr_r + (ADDR_W+1)'(1);
                ST_FINISH: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    hold_r <= 1'b0;
                end
                // Hold stays asserted so a half-loaded image can never execute.
                ST_FAIL: begin
                    err_r  <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Memory address ownership: loader while the MCU is held, MCU fetch otherwise.
    always_comb begin
        if (hold_r) MEM_ADDR = ptr_r[ADDR_W-1:0];
        else        MEM_ADDR = CPU_ADDR;
    end

    assign RX_READY   = rx_ready_r;
    assign MEM_WE     = mem_we_r;
    assign MEM_WDATA  = wdata_r;
    assign CPU_HOLD   = hold_r;
    assign BUSY       = busy_r;
    assign DONE       = done_r;
    assign ERR        = err_r;
    assign WORD_COUNT = ptr_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as word bytes are sent
// and popped by a monitor on every MEM_WE pulse.
module tb_prog_loader;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int TO = 64;

    logic          CLK = 1'b0;
    logic          RST_N, LOAD_REQ, RX_VALID, RX_READY;
    logic [7:0]    RX_DATA;
    logic [AW-1:0] CPU_ADDR, MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_WE, CPU_HOLD, BUSY, DONE, ERR;
    logic [AW:0]   WORD_COUNT;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] words_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 CLK = ~CLK;

    prog_loader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD_REQ(LOAD_REQ), .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID), .RX_READY(RX_READY), .CPU_ADDR(CPU_ADDR),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
        .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .WORD_COUNT(WORD_COUNT)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every MEM_WE pulse must match the head of the scoreboard.
    always @(negedge CLK) begin : mon
        wr_t e;
        if (RST_N && MEM_WE) begin
            check_eq("hold_during_we", 32'(CPU_HOLD), 32'd1);
            check_eq("rdy_low_in_write", 32'(RX_READY), 32'd0);
            check_eq("we_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(MEM_ADDR), 32'(e.addr));
                check_eq("wr_data", 32'(MEM_WDATA), 32'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (!RX_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check_eq("rx_accept", 32'(RX_READY), 32'd1);
        @(posedge CLK);
    endtask

    task automatic rx_idle();
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic start_load();
        @(negedge CLK);
        LOAD_REQ = 1'b1;
        @(negedge CLK);
        LOAD_REQ = 1'b0;
    endtask

    // Sends sync, length, words_q and checksum (optionally corrupted); RX_VALID stays high throughout.
    task automatic send_frame(input logic [9:0] len, input logic [7:0] chk_flip);
        logic [7:0]    c;
        logic [DW-1:0] w;
        wr_t           e;
        c = {6'd0, len[9:8]} ^ len[7:0];
        send_byte(8'hA5);
        send_byte({6'd0, len[9:8]});
        send_byte(len[7:0]);
        for (int i = 0; i <= int'(len); i++) begin
            w = words_q[i];
            send_byte({6'd0, w[17:16]});
            send_byte(w[15:8]);
            e.addr = AW'(i);
            e.data = w;
            exp_q.push_back(e);
            send_byte(w[7:0]);
            c = c ^ {6'd0, w[17:16]} ^ w[15:8] ^ w[7:0];
        end
        send_byte(c ^ chk_flip);
        rx_idle();
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(DONE || ERR) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (n >= budget) check_eq("end_wait", 32'(DONE || ERR), 32'd1);
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rdy"},   32'(RX_READY), 32'd0);
        check_eq({tag, "_we"},    32'(MEM_WE), 32'd0);
        check_eq({tag, "_hold"},  32'(CPU_HOLD), 32'd0);
        check_eq({tag, "_busy"},  32'(BUSY), 32'd0);
        check_eq({tag, "_done"},  32'(DONE), 32'd0);
        check_eq({tag, "_err"},   32'(ERR), 32'd0);
        check_eq({tag, "_wc"},    32'(WORD_COUNT), 32'd0);
        check_eq({tag, "_wdata"}, 32'(MEM_WDATA), 32'd0);
        check_eq({tag, "_addr"},  32'(MEM_ADDR), 32'(CPU_ADDR));
    endtask

    initial begin
        RST_N    = 1'b0;
        LOAD_REQ = 1'b0;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        CPU_ADDR = 10'h155;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        check_eq("reset_addr_155", 32'(MEM_ADDR), 32'h155);
        RST_N = 1'b1;

        // Good two-word frame.
        start_load();
        check_eq("start_busy", 32'(BUSY), 32'd1);
        check_eq("start_hold", 32'(CPU_HOLD), 32'd1);
        words_q = '{18'h3FFFF, 18'h01234};
        send_frame(10'h001, 8'h00);
        wait_end(50);
        check_eq("a_done", 32'(DONE), 32'd1);
        check_eq("a_err", 32'(ERR), 32'd0);
        check_eq("a_wc", 32'(WORD_COUNT), 32'd2);
        check_eq("a_hold", 32'(CPU_HOLD), 32'd0);
        check_eq("a_busy", 32'(BUSY), 32'd0);
        CPU_ADDR = 10'h2AA;
        #1;
        check_eq("a_cpu_addr", 32'(MEM_ADDR), 32'h2AA);
        check_eq("a_q_empty", 32'(exp_q.size()), 32'd0);

        // Same frame, corrupted checksum: writes happen, then the load fails with the MCU held.
        start_load();
        send_frame(10'h001, 8'h01);
        wait_end(50);
        check_eq("b_err", 32'(ERR), 32'd1);
        check_eq("b_done", 32'(DONE), 32'd0);
        check_eq("b_hold", 32'(CPU_HOLD), 32'd1);
        check_eq("b_wc", 32'(WORD_COUNT), 32'd2);
        check_eq("b_addr_loader", 32'(MEM_ADDR), 32'd2);
        check_eq("b_q_empty", 32'(exp_q.size()), 32'd0);

        // Leading junk before sync is dropped; retry clears the hold.
        start_load();
        check_eq("c_err_cleared", 32'(ERR), 32'd0);
        send_byte(8'h00);
        send_byte(8'h5A);
        words_q = '{18'h00007};
        send_frame(10'h000, 8'h00);
        wait_end(50);
        check_eq("c_done", 32'(DONE), 32'd1);
        check_eq("c_wc", 32'(WORD_COUNT), 32'd1);
        check_eq("c_hold", 32'(CPU_HOLD), 32'd0);

        // Bad B2 byte fails on arrival with no write.
        start_load();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        rx_idle();
        wait_end(20);
        check_eq("d_err", 32'(ERR), 32'd1);
        check_eq("d_wc", 32'(WORD_COUNT), 32'd0);
        check_eq("d_rdy", 32'(RX_READY), 32'd0);

        // Full 1024-word image: last write at 0x3FF, no wrap.
        words_q.delete();
        for (int i = 0; i < 1024; i++) words_q.push_back(18'((i * 1237 + 99) ^ (i << 7)));
        start_load();
        send_frame(10'h3FF, 8'h00);
        wait_end(50);
        check_eq("e_done", 32'(DONE), 32'd1);
        check_eq("e_wc", 32'(WORD_COUNT), 32'd1024);
        check_eq("e_q_empty", 32'(exp_q.size()), 32'd0);

        // Stall after the length bytes: watchdog fires, not before its budget.
        start_load();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        rx_idle();
        repeat (40) @(negedge CLK);
        check_eq("f_err_early", 32'(ERR), 32'd0);
        check_eq("f_busy", 32'(BUSY), 32'd1);
        wait_end(100);
        check_eq("f_err", 32'(ERR), 32'd1);
        check_eq("f_done", 32'(DONE), 32'd0);
        check_eq("f_hold", 32'(CPU_HOLD), 32'd1);

        // Reset in the middle of B1.
        start_load();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        @(negedge CLK);
        RST_N    = 1'b0;
        RX_VALID = 1'b0;
        @(negedge CLK);
        check_all_zero("midrst");
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
